// File: rtl/dual_port_ram_be.sv
// Single-clock true dual-port RAM with byte enables, RDW mode select, collision
// counting and optional output register. Define DUAL_PORT_RAM_CLEAR_EN for the clear engine.
module dual_port_ram_be #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 128,
  parameter int unsigned OUTPUT_REG = 0,
  parameter int unsigned RDW_MODE   = 0,
  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH,
  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  port_a_en,
  input  logic                  port_a_wr,
  input  logic [NB-1:0]         port_a_be,
  input  logic [AW-1:0]         port_a_addr,
  input  logic [DATA_WIDTH-1:0] port_a_din,
  output logic [DATA_WIDTH-1:0] port_a_dout,
  output logic                  port_a_dout_valid,
  input  logic                  port_b_en,
  input  logic                  port_b_wr,
  input  logic [NB-1:0]         port_b_be,
  input  logic [AW-1:0]         port_b_addr,
  input  logic [DATA_WIDTH-1:0] port_b_din,
  output logic [DATA_WIDTH-1:0] port_b_dout,
  output logic                  port_b_dout_valid,
  output logic                  collision,
  output logic [15:0]           collision_count,
  input  logic                  clear_req,
  output logic                  clear_busy
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic          busy;
  logic [AW-1:0] clr_addr;

`ifdef DUAL_PORT_RAM_CLEAR_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(MEM_DEPTH - 1)) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  // Reset parks the engine in CLEAR so memory is wiped right after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  assign clr_addr   = clr_addr_q;
  assign clear_busy = busy;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign busy             = 1'b0;
  assign clr_addr         = '0;
  assign clear_busy       = 1'b0;
`endif

  logic acc_a, acc_b, in_a, in_b, wr_a, wr_b, same_addr, coll_now;

  assign acc_a     = port_a_en & ~busy;
  assign acc_b     = port_b_en & ~busy;
  assign in_a      = ({1'b0, port_a_addr} < (AW + 1)'(MEM_DEPTH));
  assign in_b      = ({1'b0, port_b_addr} < (AW + 1)'(MEM_DEPTH));
  assign wr_a      = acc_a & port_a_wr & in_a;
  assign wr_b      = acc_b & port_b_wr & in_b;
  assign same_addr = (port_a_addr == port_b_addr);
  assign coll_now  = acc_a & acc_b & in_a & in_b & same_addr & (port_a_wr | port_b_wr);

  // B lanes are written first so port A wins any overlapping lane.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && port_b_be[i]) begin
          mem[port_b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wr_a && port_a_be[i]) begin
          mem[port_a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  // Write-first merges every same-cycle write to the addressed word, A over B.
  always_comb begin
    rd_a = in_a ? mem[port_a_addr] : '0;
    rd_b = in_b ? mem[port_b_addr] : '0;
    if (RDW_MODE != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && port_b_be[i] && same_addr) begin
          rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = port_b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wr_a && port_a_be[i]) begin
          rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = port_a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wr_b && port_b_be[i]) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = port_b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wr_a && port_a_be[i] && same_addr) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = port_a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
  logic                  valid_a_q, valid_b_q;
  logic                  coll_q;
  logic [15:0]           count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q  <= '0;
      dout_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      valid_a_q <= acc_a;
      valid_b_q <= acc_b;
      if (acc_a) dout_a_q <= rd_a;
      if (acc_b) dout_b_q <= rd_b;
      coll_q <= coll_now;
      if (coll_now && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
    end
  end

  assign collision       = coll_q;
  assign collision_count = count_q;

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] dout_a_q2, dout_b_q2;
    logic                  valid_a_q2, valid_b_q2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_a_q2  <= '0;
        dout_b_q2  <= '0;
        valid_a_q2 <= 1'b0;
        valid_b_q2 <= 1'b0;
      end else begin
        valid_a_q2 <= valid_a_q;
        valid_b_q2 <= valid_b_q;
        if (valid_a_q) dout_a_q2 <= dout_a_q;
        if (valid_b_q) dout_b_q2 <= dout_b_q;
      end
    end

    assign port_a_dout       = dout_a_q2;
    assign port_b_dout       = dout_b_q2;
    assign port_a_dout_valid = valid_a_q2;
    assign port_b_dout_valid = valid_b_q2;
  end else begin : g_noreg
    assign port_a_dout       = dout_a_q;
    assign port_b_dout       = dout_b_q;
    assign port_a_dout_valid = valid_a_q;
    assign port_b_dout_valid = valid_b_q;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances (read-first/no output reg, write-first/output reg)
// share stimulus; a reference memory model feeds per-port scoreboards.
module tb_dual_port_ram_be;
  localparam int unsigned DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear_req;
  logic        a_en, a_wr, b_en, b_wr;
  logic [7:0]  a_be, b_be;
  logic [6:0]  a_addr, b_addr;
  logic [63:0] a_din, b_din;

  logic [63:0] dout [4];
  logic        dv   [4];
  logic        coll [2];
  logic [15:0] cnt  [2];
  logic        busy [2];

  dual_port_ram_be #(.OUTPUT_REG(0), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .port_a_en(a_en), .port_a_wr(a_wr), .port_a_be(a_be), .port_a_addr(a_addr),
    .port_a_din(a_din), .port_a_dout(dout[0]), .port_a_dout_valid(dv[0]),
    .port_b_en(b_en), .port_b_wr(b_wr), .port_b_be(b_be), .port_b_addr(b_addr),
    .port_b_din(b_din), .port_b_dout(dout[1]), .port_b_dout_valid(dv[1]),
    .collision(coll[0]), .collision_count(cnt[0]), .clear_req(clear_req),
    .clear_busy(busy[0])
  );

  dual_port_ram_be #(.OUTPUT_REG(1), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .port_a_en(a_en), .port_a_wr(a_wr), .port_a_be(a_be), .port_a_addr(a_addr),
    .port_a_din(a_din), .port_a_dout(dout[2]), .port_a_dout_valid(dv[2]),
    .port_b_en(b_en), .port_b_wr(b_wr), .port_b_be(b_be), .port_b_addr(b_addr),
    .port_b_din(b_din), .port_b_dout(dout[3]), .port_b_dout_valid(dv[3]),
    .collision(coll[1]), .collision_count(cnt[1]), .clear_req(clear_req),
    .clear_busy(busy[1])
  );

  typedef struct {
    int unsigned due;
    logic [63:0] data;
    bit          known;
  } exp_t;

  typedef struct {
    logic [6:0]  addr;
    logic [63:0] pre;
    logic [7:0]  be;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  int unsigned n_chk = 0, n_fail = 0, cyc = 0;
  logic [63:0] mem_m [DEPTH];
  bit          known [DEPTH];
  exp_t        q     [4][$];
  logic [63:0] last  [4];
  bit          lastk [4];
  bit          exp_coll, exp_busy;
  logic [15:0] exp_cnt;
  int          clr_left;
  vec_t        vecs  [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic mwrite(input logic [6:0] addr, input logic [7:0] be, input logic [63:0] din);
    for (int i = 0; i < 8; i++) if (be[i]) mem_m[addr][i*8 +: 8] = din[i*8 +: 8];
    if (be == 8'hFF) known[addr] = 1'b1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      known[i] = 1'b1;
    end
  endtask

  task automatic check_all();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      if (q[s].size() > 0 && q[s][0].due == cyc) begin
        e = q[s].pop_front();
        chk($sformatf("valid_s%0d", s), 64'(dv[s]), 64'd1);
        if (e.known) chk($sformatf("dout_s%0d", s), dout[s], e.data);
        last[s]  = e.data;
        lastk[s] = e.known;
      end else begin
        chk($sformatf("novalid_s%0d", s), 64'(dv[s]), 64'd0);
        if (lastk[s]) chk($sformatf("hold_s%0d", s), dout[s], last[s]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("coll_d%0d", d), 64'(coll[d]), 64'(exp_coll));
      chk($sformatf("count_d%0d", d), 64'(cnt[d]), 64'(exp_cnt));
      chk($sformatf("busy_d%0d", d), 64'(busy[d]), 64'(exp_busy));
    end
  endtask

  // Model the edge from pre-edge inputs, push expected reads, then advance one cycle.
  task automatic step(input bit do_chk = 1'b1);
    logic [63:0] rf_a, rf_b, wf_a, wf_b;
    bit rk_a, rk_b, wk_a, wk_b, acc_a, acc_b, coll_n;
    acc_a = rst_n && a_en && !exp_busy;
    acc_b = rst_n && b_en && !exp_busy;
    rf_a = mem_m[a_addr];
    rk_a = known[a_addr];
    rf_b = mem_m[b_addr];
    rk_b = known[b_addr];
    if (acc_b && b_wr) mwrite(b_addr, b_be, b_din);
    if (acc_a && a_wr) mwrite(a_addr, a_be, a_din);
    wf_a = mem_m[a_addr];
    wk_a = known[a_addr];
    wf_b = mem_m[b_addr];
    wk_b = known[b_addr];
    if (acc_a) begin
      q[0].push_back('{due: cyc + 1, data: rf_a, known: rk_a});
      q[2].push_back('{due: cyc + 2, data: wf_a, known: wk_a});
    end
    if (acc_b) begin
      q[1].push_back('{due: cyc + 1, data: rf_b, known: rk_b});
      q[3].push_back('{due: cyc + 2, data: wf_b, known: wk_b});
    end
    coll_n = acc_a && acc_b && (a_addr == b_addr) && (a_wr || b_wr);
    if (coll_n && exp_cnt != 16'hFFFF) exp_cnt++;
`ifdef DUAL_PORT_RAM_CLEAR_EN
    if (rst_n) begin
      if (exp_busy) begin
        clr_left--;
        if (clr_left == 0) exp_busy = 1'b0;
      end else if (clear_req) begin
        exp_busy = 1'b1;
        clr_left = DEPTH;
        zero_model();
      end
    end
`endif
    @(posedge clk);
    cyc++;
    exp_coll = coll_n;
    if (do_chk) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_a(input bit en, input bit wr, input logic [7:0] be, input logic [6:0] addr,
                       input logic [63:0] din);
    a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic set_b(input bit en, input bit wr, input logic [7:0] be, input logic [6:0] addr,
                       input logic [63:0] din);
    b_en = en; b_wr = wr; b_be = be; b_addr = addr; b_din = din;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 8'h00, 7'd0, 64'd0);
    set_b(1'b0, 1'b0, 8'h00, 7'd0, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      q[s].delete();
      last[s]  = '0;
      lastk[s] = 1'b1;
    end
    exp_coll = 1'b0;
    exp_cnt  = '0;
`ifdef DUAL_PORT_RAM_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rst_valid_s%0d", s), 64'(dv[s]), 64'd0);
      chk($sformatf("rst_dout_s%0d", s), dout[s], 64'd0);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_coll_d%0d", d), 64'(coll[d]), 64'd0);
      chk($sformatf("rst_count_d%0d", d), 64'(cnt[d]), 64'd0);
      chk($sformatf("rst_busy_d%0d", d), 64'(busy[d]), 64'(exp_busy));
    end
    idle();
    clear_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
`ifdef DUAL_PORT_RAM_CLEAR_EN
    clr_left = DEPTH;
    zero_model();
    repeat (DEPTH) step();
`endif
  endtask

  initial begin
    vecs[0] = '{7'd5,   64'h0,                    8'hFF, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF};
    vecs[1] = '{7'd3,   64'h0,                    8'h0F, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{7'd7,   64'hFFFF_FFFF_FFFF_FFFF,  8'h81, 64'h0,
                64'h00FF_FFFF_FFFF_FF00};
    vecs[3] = '{7'd10,  64'h1111_1111_1111_1111,  8'hF0, 64'hAAAA_AAAA_AAAA_AAAA,
                64'hAAAA_AAAA_1111_1111};
    vecs[4] = '{7'd127, 64'h0,                    8'h3C, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_FFFF_FFFF_0000};
    vecs[5] = '{7'd0,   64'h0123_4567_89AB_CDEF,  8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0123_4567_89AB_CDEF};

    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      known[i] = 1'b0;
    end
    exp_busy  = 1'b0;
    clr_left  = 0;
    clear_req = 1'b0;
    idle();
    rst_n = 1'b1;
    #1;
    do_reset();

    // Give every word a known value.
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_a(1'b1, 1'b1, 8'hFF, 7'(i), 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1));
      set_b(1'b1, 1'b1, 8'hFF, 7'(i + 64), 64'hC2B2_AE3D_27D4_EB4F * 64'(i + 1));
      step();
    end
    idle();
    step();

    for (int v = 0; v < 6; v++) begin
      set_a(1'b1, 1'b1, 8'hFF, vecs[v].addr, vecs[v].pre);
      step();
      set_a(1'b1, 1'b1, vecs[v].be, vecs[v].addr, vecs[v].din);
      step();
      idle();
      set_b(1'b1, 1'b0, 8'h00, vecs[v].addr, 64'd0);
      step();
      idle();
      step();
      step();
      chk($sformatf("tbl%0d_rf", v), dout[1], vecs[v].exp);
      chk($sformatf("tbl%0d_wf", v), dout[3], vecs[v].exp);
    end

    // en=0 with wr=1 must not write.
    set_a(1'b0, 1'b1, 8'hFF, 7'd5, 64'hDEAD_BEEF_DEAD_BEEF);
    step();
    idle();
    set_b(1'b1, 1'b0, 8'h00, 7'd5, 64'd0);
    step();
    idle();
    step();
    step();
    chk("en0_rf", dout[1], 64'h0123_4567_89AB_CDEF);
    chk("en0_wf", dout[3], 64'h0123_4567_89AB_CDEF);

    // Read-during-write across ports.
    set_a(1'b1, 1'b1, 8'hFF, 7'd2, 64'd0);
    step();
    set_a(1'b1, 1'b1, 8'hFF, 7'd2, 64'd1);
    set_b(1'b1, 1'b0, 8'h00, 7'd2, 64'd0);
    step();
    idle();
    step();
    step();
    chk("rdw_old", dout[1], 64'd0);
    chk("rdw_new", dout[3], 64'd1);

    // Reset with reads in flight.
    set_b(1'b1, 1'b0, 8'h00, 7'd5, 64'd0);
    set_a(1'b1, 1'b0, 8'h00, 7'd7, 64'd0);
    step(1'b0);
    #2;
    do_reset();
    repeat (3) step();
    set_b(1'b1, 1'b0, 8'h00, 7'd5, 64'd0);
    step();
    idle();
    step();
    step();

    // Collision: both write addr 9.
    set_a(1'b1, 1'b1, 8'hFF, 7'd9, 64'hAAAA_AAAA_AAAA_AAAA);
    set_b(1'b1, 1'b1, 8'h81, 7'd9, 64'h5555_5555_5555_5555);
    step();
    chk("coll_pulse0", 64'(coll[0]), 64'd1);
    chk("coll_pulse1", 64'(coll[1]), 64'd1);
    chk("coll_cnt0", 64'(cnt[0]), 64'd1);
    chk("coll_cnt1", 64'(cnt[1]), 64'd1);
    idle();
    set_b(1'b1, 1'b0, 8'h00, 7'd9, 64'd0);
    step();
    idle();
    step();
    step();
    chk("coll_word_rf", dout[1], 64'hAAAA_AAAA_AAAA_AAAA);
    chk("coll_word_wf", dout[3], 64'hAAAA_AAAA_AAAA_AAAA);

    for (int n = 0; n < 300; n++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom()),
            7'($urandom_range(0, 7)), {$urandom(), $urandom()});
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom()),
            7'($urandom_range(0, 7)), {$urandom(), $urandom()});
      step();
    end

`ifdef DUAL_PORT_RAM_CLEAR_EN
    idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    set_a(1'b1, 1'b1, 8'hFF, 7'd4, 64'h1234);
    set_b(1'b1, 1'b0, 8'h00, 7'd4, 64'd0);
    repeat (5) step();
    idle();
    repeat (DEPTH - 5) step();
    for (int i = 0; i < 8; i++) begin
      set_b(1'b1, 1'b0, 8'h00, 7'(i * 16 + 3), 64'd0);
      step();
    end
    idle();
    step();
    step();
    chk("clr_read_wf", dout[3], 64'd0);
`endif

    for (int n = 0; n < 70000; n++) begin
      set_a(1'b1, 1'b1, 8'hFF, 7'd9, 64'hAAAA_AAAA_AAAA_AAAA);
      set_b(1'b1, 1'b1, 8'h81, 7'd9, 64'h5555_5555_5555_5555);
      step();
    end
    chk("sat_cnt0", 64'(cnt[0]), 64'hFFFF);
    chk("sat_cnt1", 64'(cnt[1]), 64'hFFFF);
    idle();
    step();
    chk("sat_hold0", 64'(cnt[0]), 64'hFFFF);
    chk("sat_nopulse0", 64'(coll[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
